// File: rtl/ccd_bridge.sv
// ---------------------------------------------------------------------------
// ccd_bridge
//   Single-clock rate bridge from the core memory bus to a slow peripheral
//   bus. The slow side only advances on slow_tick, which fires once every
//   clock_rate fast cycles. Requests are queued in a small FIFO and issued in
//   order, one at a time. Each response comes back to the core as a
//   one-cycle memory_ready pulse. A slow target that never answers is cut
//   off after `timeout` ticks with an error response.
//
// Ports
//   reset              in   async active-low reset
//   clock              in   single clock for all logic
//   memory_valid       in   request pulse (at most one per cycle)
//   memory_instr       in   request is an instruction fetch
//   memory_addr        in   [31:0] request address
//   memory_wdata       in   [31:0] write data
//   memory_wstrb       in   [3:0] byte strobes, 0 = read
//   memory_rdata       out  [31:0] response data, 0 unless memory_ready
//   memory_ready       out  one-cycle response pulse
//   memory_error       out  with memory_ready: timeout response
//   memory_full        out  FIFO full, master must hold off
//   memory_overflow    out  sticky: a request was dropped while full
//   slow_tick          out  slow-bus enable, one cycle per clock_rate
//   memory_slow_valid  out  slow request, held for one slow period
//   memory_slow_instr  out  slow request fields, 0 when not valid
//   memory_slow_addr   out  [31:0]
//   memory_slow_wdata  out  [31:0]
//   memory_slow_wstrb  out  [3:0]
//   memory_slow_rdata  in   [31:0] slow response data (sampled on tick)
//   memory_slow_ready  in   slow response strobe (sampled on tick)
// ---------------------------------------------------------------------------
module ccd_bridge #(
    parameter int clock_rate = 4,
    parameter int depth      = 4,
    parameter int timeout    = 256
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic        memory_error,
    output logic        memory_full,
    output logic        memory_overflow,
    output logic        slow_tick,
    output logic        memory_slow_valid,
    output logic        memory_slow_instr,
    output logic [31:0] memory_slow_addr,
    output logic [31:0] memory_slow_wdata,
    output logic [3:0]  memory_slow_wstrb,
    input  logic [31:0] memory_slow_rdata,
    input  logic        memory_slow_ready
);

    localparam int CW = (clock_rate > 1) ? $clog2(clock_rate) : 1;
    localparam int AW = $clog2(depth);
    localparam int EW = 69;
    localparam logic [CW-1:0] LAST_COUNT = CW'(clock_rate - 1);
    localparam logic [AW:0]   FULL_OCC   = (AW + 1)'(depth);
    localparam logic [31:0]   TO_LIMIT   = 32'(timeout);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_countNext;
    logic          r_tick;

    logic [EW-1:0] r_fifo [depth];
    logic [EW-1:0] w_head;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_occ;
    logic [AW:0]   w_occNext;
    logic          r_full;
    logic          r_overflow;
    logic          w_push;
    logic          w_pop;

    logic [1:0]    r_state;
    logic          r_sInstr;
    logic [31:0]   r_sAddr;
    logic [31:0]   r_sWdata;
    logic [3:0]    r_sWstrb;
    logic [31:0]   r_waitCount;
    logic          r_ready;
    logic [31:0]   r_rdata;
    logic          r_error;

    // The tick is registered from the next count so it lines up with
    // count == clock_rate-1 yet stays 0 while reset is held.
    always_comb begin
        w_countNext = (r_count == LAST_COUNT) ? '0 : r_count + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_countNext;
            r_tick  <= (w_countNext == LAST_COUNT);
        end
    end

    // Pop only looks at the registered occupancy, so a request pushed this
    // cycle can never be issued in the same cycle. A pop frees a slot for a
    // push arriving in the same cycle while full.
    always_comb begin
        w_pop  = (r_state == S_IDLE) && r_tick && (r_occ != '0);
        w_push = memory_valid && (!r_full || w_pop);
        w_head = r_fifo[r_rptr];
        w_occNext = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occNext = r_occ + 1'b1;
            2'b01:   w_occNext = r_occ - 1'b1;
            default: w_occNext = r_occ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {memory_instr, memory_addr, memory_wdata, memory_wstrb};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_occ  <= w_occNext;
            r_full <= (w_occNext == FULL_OCC);
            if (memory_valid && r_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Transaction FSM. Slow fields are loaded on issue and cleared when the
    // request phase ends so they read 0 whenever slow_valid is low. The
    // response registers default to 0 so they only carry data in the pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_sInstr    <= 1'b0;
            r_sAddr     <= '0;
            r_sWdata    <= '0;
            r_sWstrb    <= '0;
            r_waitCount <= '0;
            r_ready     <= 1'b0;
            r_rdata     <= '0;
            r_error     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state  <= S_REQ;
                        r_sInstr <= w_head[68];
                        r_sAddr  <= w_head[67:36];
                        r_sWdata <= w_head[35:4];
                        r_sWstrb <= w_head[3:0];
                    end
                end
                S_REQ: begin
                    if (r_tick) begin
                        r_sInstr <= 1'b0;
                        r_sAddr  <= '0;
                        r_sWdata <= '0;
                        r_sWstrb <= '0;
                        if (memory_slow_ready) begin
                            r_ready <= 1'b1;
                            r_rdata <= memory_slow_rdata;
                            r_state <= S_IDLE;
                        end else begin
                            r_waitCount <= '0;
                            r_state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_tick) begin
                        if (memory_slow_ready) begin
                            r_ready <= 1'b1;
                            r_rdata <= memory_slow_rdata;
                            r_state <= S_IDLE;
                        end else if ((timeout != 0) && (r_waitCount + 32'd1 == TO_LIMIT)) begin
                            r_ready <= 1'b1;
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_waitCount <= r_waitCount + 32'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign slow_tick         = r_tick;
    assign memory_full       = r_full;
    assign memory_overflow   = r_overflow;
    assign memory_ready      = r_ready;
    assign memory_rdata      = r_rdata;
    assign memory_error      = r_error;
    assign memory_slow_valid = (r_state == S_REQ);
    assign memory_slow_instr = r_sInstr;
    assign memory_slow_addr  = r_sAddr;
    assign memory_slow_wdata = r_sWdata;
    assign memory_slow_wstrb = r_sWstrb;

endmodule

// File: tb/tb_ccd_bridge.sv
// ---------------------------------------------------------------------------
// tb_ccd_bridge
//   Directed bench for ccd_bridge. dutA uses clock_rate=4, depth=4,
//   timeout=3; dutB uses clock_rate=1 for the fast-tick read case.
// ---------------------------------------------------------------------------
module tb_ccd_bridge;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;
    logic        memory_error;
    logic        memory_full;
    logic        memory_overflow;
    logic        slow_tick;
    logic        memory_slow_valid;
    logic        memory_slow_instr;
    logic [31:0] memory_slow_addr;
    logic [31:0] memory_slow_wdata;
    logic [3:0]  memory_slow_wstrb;
    logic [31:0] memory_slow_rdata;
    logic        memory_slow_ready;

    logic        b_reset;
    logic        b_valid;
    logic [31:0] b_addr;
    logic [31:0] b_rdata;
    logic        b_ready;
    logic        b_error;
    logic        b_full;
    logic        b_overflow;
    logic        b_slowTick;
    logic        b_slowValid;
    logic        b_slowInstr;
    logic [31:0] b_slowAddr;
    logic [31:0] b_slowWdata;
    logic [3:0]  b_slowWstrb;
    logic [31:0] b_slowRdata;
    logic        b_slowReady;

    int total = 0;
    int bad   = 0;

    ccd_bridge #(.clock_rate(4), .depth(4), .timeout(3)) dutA (
        .reset(reset), .clock(clock),
        .memory_valid(memory_valid), .memory_instr(memory_instr),
        .memory_addr(memory_addr), .memory_wdata(memory_wdata),
        .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
        .memory_ready(memory_ready), .memory_error(memory_error),
        .memory_full(memory_full), .memory_overflow(memory_overflow),
        .slow_tick(slow_tick), .memory_slow_valid(memory_slow_valid),
        .memory_slow_instr(memory_slow_instr), .memory_slow_addr(memory_slow_addr),
        .memory_slow_wdata(memory_slow_wdata), .memory_slow_wstrb(memory_slow_wstrb),
        .memory_slow_rdata(memory_slow_rdata), .memory_slow_ready(memory_slow_ready)
    );

    ccd_bridge #(.clock_rate(1), .depth(4), .timeout(256)) dutB (
        .reset(b_reset), .clock(clock),
        .memory_valid(b_valid), .memory_instr(1'b0),
        .memory_addr(b_addr), .memory_wdata(32'h0),
        .memory_wstrb(4'h0), .memory_rdata(b_rdata),
        .memory_ready(b_ready), .memory_error(b_error),
        .memory_full(b_full), .memory_overflow(b_overflow),
        .slow_tick(b_slowTick), .memory_slow_valid(b_slowValid),
        .memory_slow_instr(b_slowInstr), .memory_slow_addr(b_slowAddr),
        .memory_slow_wdata(b_slowWdata), .memory_slow_wstrb(b_slowWstrb),
        .memory_slow_rdata(b_slowRdata), .memory_slow_ready(b_slowReady)
    );

    // Advance one cycle and settle just past the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clearReq();
        memory_valid = 1'b0;
        memory_instr = 1'b0;
        memory_addr  = 32'h0;
        memory_wdata = 32'h0;
        memory_wstrb = 4'h0;
    endtask

    task automatic pushReq(input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        memory_valid = 1'b1;
        memory_instr = instr;
        memory_addr  = addr;
        memory_wdata = wdata;
        memory_wstrb = wstrb;
    endtask

    // OR of every dutA output except slow_tick.
    function automatic logic anyOutA();
        return memory_ready | memory_error | memory_full | memory_overflow |
               memory_slow_valid | memory_slow_instr | (|memory_rdata) |
               (|memory_slow_addr) | (|memory_slow_wdata) | (|memory_slow_wstrb);
    endfunction

    task automatic waitTick();
        int n = 0;
        while (slow_tick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (slow_tick !== 1'b1) begin
            bad++;
            $display("[TB] FAIL waitTick: slow_tick=%b want 1", slow_tick);
        end
    endtask

    // Wait for the given address to be issued, then for its timeout response.
    task automatic expectIssue(input logic [31:0] addr);
        int n = 0;
        while (memory_slow_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (memory_slow_valid !== 1'b1 || memory_slow_addr !== addr) begin
            bad++;
            $display("[TB] FAIL issueOrder: valid=%b addr=%h want 1 %h",
                     memory_slow_valid, memory_slow_addr, addr);
        end
        n = 0;
        while (memory_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (memory_ready !== 1'b1 || memory_error !== 1'b1 || memory_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL issueResp %h: ready=%b error=%b rdata=%h want 1 1 0",
                     addr, memory_ready, memory_error, memory_rdata);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        b_reset = 1'b0;
        clearReq();
        memory_slow_rdata = 32'h0;
        memory_slow_ready = 1'b0;
        b_valid = 1'b0;
        b_addr = 32'h0;
        b_slowRdata = 32'h12345678;
        b_slowReady = 1'b1;
        step();
        step();
        total++;
        if (anyOutA() !== 1'b0 || slow_tick !== 1'b0) begin
            bad++;
            $display("[TB] FAIL inReset: outputs=%b tick=%b want 0 0", anyOutA(), slow_tick);
        end
        total++;
        if (b_slowTick !== 1'b0 || b_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL inResetB: tick=%b ready=%b want 0 0", b_slowTick, b_ready);
        end
        reset = 1'b1;
        b_reset = 1'b1;
        for (int n = 0; n < 12; n++) begin
            total++;
            if (slow_tick !== ((n % 4) == 3)) begin
                bad++;
                $display("[TB] FAIL tickCycle%0d: slow_tick=%b want %b", n, slow_tick, ((n % 4) == 3));
            end
            total++;
            if (anyOutA() !== 1'b0) begin
                bad++;
                $display("[TB] FAIL idleOut%0d: outputs=%b want 0", n, anyOutA());
            end
            step();
        end
    endtask

    task automatic test_read();
        pushReq(1'b1, 32'h100, 32'h0, 4'h0);
        step();
        clearReq();
        waitTick();
        step();
        total++;
        if (memory_slow_valid !== 1'b1 || memory_slow_addr !== 32'h100 ||
            memory_slow_instr !== 1'b1 || memory_slow_wstrb !== 4'h0) begin
            bad++;
            $display("[TB] FAIL readIssue: valid=%b addr=%h instr=%b wstrb=%h want 1 100 1 0",
                     memory_slow_valid, memory_slow_addr, memory_slow_instr, memory_slow_wstrb);
        end
        memory_slow_ready = 1'b1;
        memory_slow_rdata = 32'hDEADBEEF;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (memory_slow_valid !== 1'b1 || memory_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL readHold%0d: valid=%b ready=%b want 1 0",
                         i, memory_slow_valid, memory_ready);
            end
            step();
        end
        total++;
        if (memory_ready !== 1'b1 || memory_rdata !== 32'hDEADBEEF || memory_error !== 1'b0) begin
            bad++;
            $display("[TB] FAIL readResp: ready=%b rdata=%h error=%b want 1 deadbeef 0",
                     memory_ready, memory_rdata, memory_error);
        end
        total++;
        if (memory_slow_valid !== 1'b0 || memory_slow_addr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL readRelease: valid=%b addr=%h want 0 0",
                     memory_slow_valid, memory_slow_addr);
        end
        memory_slow_ready = 1'b0;
        memory_slow_rdata = 32'h0;
        step();
        total++;
        if (memory_ready !== 1'b0 || memory_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL readPulse: ready=%b rdata=%h want 0 0", memory_ready, memory_rdata);
        end
    endtask

    task automatic test_rate1();
        total++;
        if (b_slowTick !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rate1Tick: slow_tick=%b want 1", b_slowTick);
        end
        b_valid = 1'b1;
        b_addr = 32'h100;
        step();
        b_valid = 1'b0;
        b_addr = 32'h0;
        total++;
        if (b_slowValid !== 1'b0 || b_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rate1Land: valid=%b ready=%b want 0 0", b_slowValid, b_ready);
        end
        step();
        total++;
        if (b_slowValid !== 1'b1 || b_slowAddr !== 32'h100 || b_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rate1Issue: valid=%b addr=%h ready=%b want 1 100 0",
                     b_slowValid, b_slowAddr, b_ready);
        end
        step();
        total++;
        if (b_ready !== 1'b1 || b_rdata !== 32'h12345678 || b_error !== 1'b0 || b_slowValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rate1Resp: ready=%b rdata=%h error=%b valid=%b want 1 12345678 0 0",
                     b_ready, b_rdata, b_error, b_slowValid);
        end
        step();
        total++;
        if (b_ready !== 1'b0 || b_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL rate1Pulse: ready=%b rdata=%h want 0 0", b_ready, b_rdata);
        end
    endtask

    task automatic test_timeout_overflow();
        int n = 0;
        bit seen = 0;
        pushReq(1'b0, 32'h200, 32'hCAFEF00D, 4'hF);
        step();
        clearReq();
        while (memory_slow_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (memory_slow_valid !== 1'b1 || memory_slow_addr !== 32'h200 ||
            memory_slow_wdata !== 32'hCAFEF00D || memory_slow_wstrb !== 4'hF) begin
            bad++;
            $display("[TB] FAIL writeIssue: valid=%b addr=%h wdata=%h wstrb=%h want 1 200 cafef00d f",
                     memory_slow_valid, memory_slow_addr, memory_slow_wdata, memory_slow_wstrb);
        end
        // k counts cycles from the first request-phase cycle of 0x200.
        for (int k = 0; k <= 20; k++) begin
            if (k >= 1 && k <= 15) begin
                total++;
                if (memory_ready !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL earlyResp k=%0d: ready=%b want 0", k, memory_ready);
                end
            end
            if (k == 3) begin
                total++;
                if (memory_full !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL fullEarly: full=%b want 0", memory_full);
                end
            end
            if (k == 4) begin
                total++;
                if (memory_full !== 1'b1 || memory_overflow !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL fullAfter4: full=%b overflow=%b want 1 0",
                             memory_full, memory_overflow);
                end
            end
            if (k == 5) begin
                total++;
                if (memory_overflow !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL overflowSet: overflow=%b want 1", memory_overflow);
                end
            end
            if (k == 16) begin
                total++;
                if (memory_ready !== 1'b1 || memory_error !== 1'b1 || memory_rdata !== 32'h0) begin
                    bad++;
                    $display("[TB] FAIL timeoutResp: ready=%b error=%b rdata=%h want 1 1 0",
                             memory_ready, memory_error, memory_rdata);
                end
            end
            if (k == 20) begin
                total++;
                if (memory_slow_valid !== 1'b1 || memory_slow_addr !== 32'h300 || memory_full !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL nextIssue: valid=%b addr=%h full=%b want 1 300 0",
                             memory_slow_valid, memory_slow_addr, memory_full);
                end
            end
            if (k <= 4) begin
                pushReq(1'b0, 32'h300 + 32'(k * 16), 32'(k), 4'h0);
            end else begin
                clearReq();
            end
            if (k < 20) begin
                step();
            end
        end
        expectIssue(32'h300);
        expectIssue(32'h310);
        expectIssue(32'h320);
        expectIssue(32'h330);
        for (int i = 0; i < 30; i++) begin
            if (memory_slow_valid === 1'b1) begin
                seen = 1;
            end
            step();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL droppedIssued: saw slow_valid=1 want 0");
        end
        total++;
        if (memory_overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL overflowSticky: overflow=%b want 1", memory_overflow);
        end
    endtask

    task automatic test_full_pop();
        reset = 1'b0;
        #1;
        total++;
        if (memory_overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overflowReset: overflow=%b want 0", memory_overflow);
        end
        step();
        reset = 1'b1;
        waitTick();
        pushReq(1'b0, 32'h400, 32'h0, 4'h0);
        step();
        pushReq(1'b0, 32'h410, 32'h0, 4'h0);
        step();
        pushReq(1'b0, 32'h420, 32'h0, 4'h0);
        step();
        pushReq(1'b0, 32'h430, 32'h0, 4'h0);
        step();
        total++;
        if (memory_full !== 1'b1 || slow_tick !== 1'b1 || memory_slow_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fullAtTick: full=%b tick=%b valid=%b want 1 1 0",
                     memory_full, slow_tick, memory_slow_valid);
        end
        pushReq(1'b0, 32'h440, 32'h0, 4'h0);
        step();
        clearReq();
        total++;
        if (memory_full !== 1'b1 || memory_overflow !== 1'b0 ||
            memory_slow_valid !== 1'b1 || memory_slow_addr !== 32'h400) begin
            bad++;
            $display("[TB] FAIL pushOnPop: full=%b overflow=%b valid=%b addr=%h want 1 0 1 400",
                     memory_full, memory_overflow, memory_slow_valid, memory_slow_addr);
        end
        expectIssue(32'h400);
        expectIssue(32'h410);
        expectIssue(32'h420);
        expectIssue(32'h430);
        expectIssue(32'h440);
        total++;
        if (memory_overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL noOverflow: overflow=%b want 0", memory_overflow);
        end
    endtask

    task automatic test_reset_midflight();
        int n = 0;
        bit seen = 0;
        waitTick();
        pushReq(1'b0, 32'h500, 32'h0, 4'h0);
        step();
        pushReq(1'b0, 32'h510, 32'h0, 4'h0);
        step();
        pushReq(1'b0, 32'h520, 32'h0, 4'h0);
        step();
        clearReq();
        while (memory_slow_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n = 0;
        while (memory_slow_valid !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        total++;
        if (memory_slow_valid !== 1'b0 || memory_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reachWait: valid=%b ready=%b want 0 0", memory_slow_valid, memory_ready);
        end
        reset = 1'b0;
        #1;
        total++;
        if (anyOutA() !== 1'b0 || slow_tick !== 1'b0) begin
            bad++;
            $display("[TB] FAIL asyncReset: outputs=%b tick=%b want 0 0", anyOutA(), slow_tick);
        end
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (memory_ready === 1'b1 || memory_slow_valid === 1'b1) begin
                seen = 1;
            end
            step();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL postReset: saw ready or slow_valid want none");
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_rate1();
        test_timeout_overflow();
        test_full_pop();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
